// File: rtl/io_cmd_pkg.sv
// Shared types and constants for the io_cmd_frontend command path.
// Default operand/opcode widths also serve as the top-level parameter defaults.
package io_cmd_pkg;

   localparam int OPW_DFLT  = 3;
   localparam int OPCW_DFLT = 4;
   localparam int OVF_W     = 8;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } deb_state_e;

   typedef struct packed {
      logic [OPCW_DFLT-1:0] op;
      logic [OPW_DFLT-1:0]  a;
      logic [OPW_DFLT-1:0]  b;
   } cmd_t;

endpackage

// File: rtl/io_cmd_frontend_if.sv
// Valid/ready command bus from the front-end FIFO head to the ALU/display path.
interface io_cmd_frontend_if #(
   parameter int OPW  = 3,
   parameter int OPCW = 4
) ();

   logic            cmd_valid;
   logic            cmd_ready;
   logic [OPW-1:0]  cmd_a;
   logic [OPW-1:0]  cmd_b;
   logic [OPCW-1:0] cmd_op;

   modport master (output cmd_valid, output cmd_a, output cmd_b, output cmd_op, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_a, input cmd_b, input cmd_op, output cmd_ready);

endinterface

// File: rtl/cmd_debounce.sv
// go-button synchroniser and debounce FSM producing a one-cycle press strobe.
// IO_CMD_REPEAT_EN adds auto-repeat presses every REPEAT_CYCLES cycles held in HIGH.
module cmd_debounce
   import io_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = 4
`ifdef IO_CMD_REPEAT_EN
   , parameter int REPEAT_CYCLES = 1024
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic go,
   output logic press,
   output logic go_level
);

   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             go_p0, go_p1;
   deb_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             edge_press;

   // stage 0/1: two-flop synchroniser
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         go_p0 <= 1'b0;
         go_p1 <= 1'b0;
      end else begin
         go_p0 <= go;
         go_p1 <= go_p0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOW;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      edge_press = 1'b0;
      case (state)
         LOW: if (go_p1) begin
            state_nxt = RISE_CHK;
            cnt_nxt   = '0;
         end
         RISE_CHK: begin
            if (!go_p1) state_nxt = LOW;
            else if (cnt == CNT_LAST) begin
               state_nxt  = HIGH;
               edge_press = 1'b1;
            end else cnt_nxt = cnt + 1'b1;
         end
         HIGH: if (!go_p1) begin
            state_nxt = FALL_CHK;
            cnt_nxt   = '0;
         end
         FALL_CHK: begin
            if (go_p1) state_nxt = HIGH;
            else if (cnt == CNT_LAST) state_nxt = LOW;
            else cnt_nxt = cnt + 1'b1;
         end
         default: state_nxt = LOW;
      endcase
   end

   assign go_level = (state == HIGH) || (state == FALL_CHK);

`ifdef IO_CMD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_fire;

   // Any visit outside HIGH (including a FALL_CHK excursion) restarts the period.
   assign rep_fire = (state == HIGH) && (rep_cnt == REP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               rep_cnt <= '0;
      else if (state != HIGH)   rep_cnt <= '0;
      else if (rep_fire)        rep_cnt <= '0;
      else                      rep_cnt <= rep_cnt + 1'b1;
   end

   assign press = edge_press | rep_fire;
`else
   assign press = edge_press;
`endif

endmodule

// File: rtl/io_cmd_frontend.sv
// Command front-end: operand synchronisers, debounced go, and a command FIFO
// feeding a valid/ready bus. Optional auto-repeat via IO_CMD_REPEAT_EN.
module io_cmd_frontend
   import io_cmd_pkg::*;
#(
   parameter int OPW        = OPW_DFLT,
   parameter int OPCW       = OPCW_DFLT,
   parameter int DEPTH      = 4,
   parameter int DEB_CYCLES = 4
`ifdef IO_CMD_REPEAT_EN
   , parameter int REPEAT_CYCLES = 1024
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [OPW-1:0]             a,
   input  logic [OPW-1:0]             b,
   input  logic [OPCW-1:0]            op_code,
   input  logic                       go,
   io_cmd_frontend_if.master          bus,
   output logic                       go_level,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic [OVF_W-1:0]           overflow_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [OPCW-1:0] op;
      logic [OPW-1:0]  a;
      logic [OPW-1:0]  b;
   } word_t;

   logic [OPW-1:0]  a_p0, a_p1, b_p0, b_p1;
   logic [OPCW-1:0] op_p0, op_p1;
   logic            press, full, pop, push_ok;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level;
   word_t           mem [DEPTH];
   word_t           head;

   // stage 0/1: operand synchronisers (not debounced)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_p0 <= '0; a_p1 <= '0;
         b_p0 <= '0; b_p1 <= '0;
         op_p0 <= '0; op_p1 <= '0;
      end else begin
         a_p0 <= a;        a_p1 <= a_p0;
         b_p0 <= b;        b_p1 <= b_p0;
         op_p0 <= op_code; op_p1 <= op_p0;
      end
   end

   cmd_debounce #(
      .DEB_CYCLES    (DEB_CYCLES)
`ifdef IO_CMD_REPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
   ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .press    (press),
      .go_level (go_level)
   );

   assign full    = (level == LW'(DEPTH));
   assign pop     = bus.cmd_valid && bus.cmd_ready;
   assign push_ok = press && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= '{op: op_p1, a: a_p1, b: b_p1};
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (press && full && !pop && (overflow_cnt != '1))
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

   // Head is masked while empty so stale storage never reaches the bus.
   assign head          = mem[rd_ptr];
   assign bus.cmd_valid = (level != '0);
   assign bus.cmd_a     = bus.cmd_valid ? head.a  : '0;
   assign bus.cmd_b     = bus.cmd_valid ? head.b  : '0;
   assign bus.cmd_op    = bus.cmd_valid ? head.op : '0;
   assign fifo_level    = level;

endmodule

// File: tb/tb_io_cmd_frontend.sv
// Scoreboard bench for io_cmd_frontend (DEPTH=4, DEB_CYCLES=4); the auto-repeat
// scenario runs only when IO_CMD_REPEAT_EN is defined (REPEAT_CYCLES=8).
module tb_io_cmd_frontend;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] a, b;
   logic [3:0] op_code;
   logic       go;
   logic       go_level;
   logic [2:0] fifo_level;
   logic [7:0] overflow_cnt;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   io_cmd_frontend_if #(.OPW(3), .OPCW(4)) bus ();

   io_cmd_frontend #(
      .OPW(3), .OPCW(4), .DEPTH(4), .DEB_CYCLES(4)
`ifdef IO_CMD_REPEAT_EN
      , .REPEAT_CYCLES(8)
`endif
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .a            (a),
      .b            (b),
      .op_code      (op_code),
      .go           (go),
      .bus          (bus),
      .go_level     (go_level),
      .fifo_level   (fifo_level),
      .overflow_cnt (overflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One clean press: held long enough to push, released long enough to settle in LOW.
   task automatic do_press(input logic [2:0] pa, input logic [2:0] pb, input logic [3:0] pop, input bit exp_push);
      a = pa; b = pb; op_code = pop;
      if (exp_push) exp_q.push_back({pop, pa, pb});
      go = 1'b1;
      tick(8);
      go = 1'b0;
      tick(10);
   endtask

   task automatic drain(input string name);
      bus.cmd_ready = 1'b1;
      for (int k = 0; k < 10 && bus.cmd_valid; k++) tick(1);
      bus.cmd_ready = 1'b0;
      chk({name, "_valid_low"}, bus.cmd_valid, 0);
      chk({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: every accepted head is compared with the oldest expectation.
   initial begin
      logic [9:0] got, want;
      forever begin
         @(negedge clk);
         if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
            got = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected got %h want none", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL pop_data got %h want %h", got, want);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; a = '0; b = '0; op_code = '0; go = 1'b0;
      bus.cmd_ready = 1'b0;
      tick(3);
      chk("rst_valid", bus.cmd_valid, 0);
      chk("rst_head", {bus.cmd_op, bus.cmd_a, bus.cmd_b}, 0);
      chk("rst_go_level", go_level, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow_cnt, 0);
      reset = 1'b1;
      tick(2);

      // First press latency: push on edge DEB_CYCLES+2 = 6
      a = 3'd5; b = 3'd2; op_code = 4'd5; go = 1'b1;
      exp_q.push_back({4'd5, 3'd5, 3'd2});
      tick(6);
      chk("lat_valid_edge5", bus.cmd_valid, 0);
      tick(1);
      chk("lat_valid_edge6", bus.cmd_valid, 1);
      chk("lat_op", bus.cmd_op, 5);
      chk("lat_a", bus.cmd_a, 5);
      chk("lat_b", bus.cmd_b, 2);
      chk("lat_level", fifo_level, 1);
      chk("lat_go_level", go_level, 1);
      go = 1'b0;
      tick(12);
      chk("release_go_level", go_level, 0);
      drain("t1");

      // Bounce: toggling every 2 cycles never survives debounce
      a = 3'd3; b = 3'd3; op_code = 4'd3;
      for (int i = 0; i < 20; i++) begin
         go = ~go;
         tick(2);
         chk("bounce_go_level", go_level, 0);
         chk("bounce_valid", bus.cmd_valid, 0);
      end
      go = 1'b0;
      tick(10);
      chk("bounce_level", fifo_level, 0);

      // Overflow: 6 presses into a depth-4 FIFO with consumer stalled
      for (int i = 1; i <= 6; i++)
         do_press(3'(i), 3'(7 - i), 4'(i + 8), i <= 4);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_count", overflow_cnt, 2);
      bus.cmd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_consecutive_valid", bus.cmd_valid, 1);
         tick(1);
      end
      bus.cmd_ready = 1'b0;
      chk("drain_done_valid", bus.cmd_valid, 0);
      chk("drain_sb_empty", exp_q.size(), 0);

      // Full FIFO: press lands on the same edge as a pop
      for (int i = 1; i <= 4; i++) do_press(3'(i), 3'd1, 4'd9, 1'b1);
      a = 3'd7; b = 3'd7; op_code = 4'd3; go = 1'b1;
      exp_q.push_back({4'd3, 3'd7, 3'd7});
      tick(6);
      bus.cmd_ready = 1'b1;
      tick(1);
      bus.cmd_ready = 1'b0;
      chk("fullpop_level", fifo_level, 4);
      chk("fullpop_ovf", overflow_cnt, 2);
      go = 1'b0;
      tick(10);
      drain("t4");

      // Reset mid RISE_CHK with two entries queued, go held through release
      do_press(3'd2, 3'd4, 4'd1, 1'b0);
      do_press(3'd3, 3'd5, 4'd2, 1'b0);
      chk("prerst_level", fifo_level, 2);
      a = 3'd6; b = 3'd5; op_code = 4'd12; go = 1'b1;
      tick(4);
      reset = 1'b0;
      #1;
      chk("midrst_valid", bus.cmd_valid, 0);
      chk("midrst_head", {bus.cmd_op, bus.cmd_a, bus.cmd_b}, 0);
      chk("midrst_go_level", go_level, 0);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_ovf", overflow_cnt, 0);
      exp_q.delete();
      tick(2);
      reset = 1'b1;
      exp_q.push_back({4'd12, 3'd6, 3'd5});
      tick(6);
      chk("rerun_valid_edge5", bus.cmd_valid, 0);
      tick(1);
      chk("rerun_valid_edge6", bus.cmd_valid, 1);
      chk("rerun_level", fifo_level, 1);
      go = 1'b0;
      tick(10);
      chk("rerun_single_push", fifo_level, 1);
      drain("t5");

`ifdef IO_CMD_REPEAT_EN
      // Auto-repeat: presses at HIGH entry and every 8 cycles after
      a = 3'd2; b = 3'd3; op_code = 4'd4; go = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back({4'd4, 3'd2, 3'd3});
      tick(7);
      tick(30);
      chk("rep_level", fifo_level, 4);
      chk("rep_ovf", overflow_cnt, 0);
      go = 1'b0;
      tick(10);
      drain("t6");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_cmd_frontend.md
# io_cmd_frontend

Parametrised command front-end for the pseudo-terminal. It synchronises the operand and opcode switches and debounces the `go` button. Each debounced press captures one {op, a, b} command into a small FIFO, which is presented to the ALU/display path over a valid/ready handshake. It replaces direct switch wiring into the top-level I/O block and supports wider operands, queued commands and overflow accounting.

## Interface
- `OPW`, 3, operand width for `a`/`b`
- `OPCW`, 4, opcode width
- `DEPTH`, 4, FIFO depth in commands (power of two, ≥2)
- `DEB_CYCLES`, 4, consecutive stable samples required to accept a `go` transition (≥2)
- `REPEAT_CYCLES`, 1024, auto-repeat period (used only with the macro below)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `a`  in  OPW  operand A switches (asynchronous)
- `b`  in  OPW  operand B switches (asynchronous)
- `op_code`  in  OPCW  opcode switches (asynchronous)
- `go`  in  1  raw push-button, active-high, bouncing
- `cmd_valid`  out  1  FIFO head is valid
- `cmd_ready`  in  1  consumer accepts head this cycle
- `cmd_a`, `cmd_b`  out  OPW  head operands
- `cmd_op`  out  OPCW  head opcode
- `go_level`  out  1  debounced button state (LED)
- `fifo_level`  out  $clog2(DEPTH+1)  commands queued
- `overflow_cnt`  out  8  presses dropped while full, saturating at 255

## Operation
- All of `a`, `b`, `op_code` and `go` pass through 2-FF synchronisers. Operands are not debounced; the capture uses the synchronised value at the push edge.
- Debounce FSM on synchronised `go`, with states LOW, RISE_CHK, HIGH, FALL_CHK:
  - LOW: go=1 → RISE_CHK, counter cleared.
  - RISE_CHK: go=0 → LOW. Counter increments each cycle; at count==DEB_CYCLES-1 with go=1 → HIGH and a one-cycle `press` is emitted on that edge.
  - HIGH: go=0 → FALL_CHK, counter cleared.
  - FALL_CHK: go=1 → HIGH. At count==DEB_CYCLES-1 with go=0 → LOW.
- `go_level` is 1 in HIGH and FALL_CHK.
- FIFO push: on `press`, writes {op, a, b}.
  - Full with no pop: the command is dropped and `overflow_cnt` increments (saturating).
  - Full with a simultaneous pop: the push is accepted and the level is unchanged.
- FIFO pop: on `cmd_valid && cmd_ready`. Head outputs are stable while valid and not popped.
- Empty FIFO with a simultaneous push and `cmd_ready`: the push lands and is presented next cycle. There is no fall-through.
- Pointers wrap modulo DEPTH. `fifo_level` is exact at 0 and at DEPTH.

## Timing
- Reset values: `cmd_valid`=0, `cmd_a`/`cmd_b`/`cmd_op`=0, `go_level`=0, `fifo_level`=0, `overflow_cnt`=0. FSM is in LOW, synchronisers are 0 and pointers are 0.
- Press latency, with `go` first sampled high at edge 0 and held: FSM enters RISE_CHK at edge 2 and the push occurs at edge DEB_CYCLES+2. `cmd_valid` is high after that edge.
- Pop to next head: the next entry is visible the cycle after the pop edge. `cmd_valid` falls after the edge that pops the last entry.
- Bounce shorter than DEB_CYCLES cycles returns the FSM to LOW (or HIGH) with no push.
- Reset asserted mid-press clears everything immediately. If `go` is still held after release, it is treated as a new press and pushes after DEB_CYCLES+2 edges.

## Configuration
- `IO_CMD_REPEAT_EN` defined: in HIGH, a repeat counter runs. Every REPEAT_CYCLES cycles of continuous HIGH, a further `press` is emitted, with the same push/overflow rules. The counter clears on leaving HIGH and on FALL_CHK→HIGH.
- Not defined: exactly one push per debounced press. The repeat counter and the REPEAT_CYCLES logic are absent.

## Structure
- Package `io_cmd_pkg` holds:
  - the debounce state enum (LOW, RISE_CHK, HIGH, FALL_CHK);
  - the command struct {op, a, b} built from OPW/OPCW;
  - the overflow counter width constant (8).
- Sub-module `cmd_debounce` contains the synchroniser for `go`, the FSM, the counter, the `press` and `go_level` outputs, and the optional repeat logic. The FIFO and the operand synchronisers stay in `io_cmd_frontend`.

## Test plan
- Reset, then set a=5, op_code=5, b=2 and hold `go` high from edge 0, with DEB_CYCLES=4 → `cmd_valid` high after edge 6, `cmd_op`=5, `cmd_a`=5, `cmd_b`=2, `fifo_level`=1.
- `go` toggling every 2 cycles for 40 cycles, DEB_CYCLES=4 → no push, `go_level` stays 0, `cmd_valid` stays 0.
- `cmd_ready`=0, 6 clean presses with distinct a=1..6, DEPTH=4 → `fifo_level`=4, `overflow_cnt`=2. Draining with `cmd_ready`=1 yields a=1,2,3,4 on consecutive cycles.
- FIFO full, with a press landing on the same edge as a pop → `fifo_level` stays 4, `overflow_cnt` unchanged, and the new command appears last.
- Assert `reset`=0 while in RISE_CHK with 2 entries queued → all outputs at reset values immediately. After release with `go` still held, one push occurs after DEB_CYCLES+2 edges.
- With `IO_CMD_REPEAT_EN` defined and REPEAT_CYCLES=8, hold `go` for 30 cycles after reaching HIGH → 1+3 pushes, `fifo_level`=4.
